// File: rtl/edge_period_meter_pkg.sv
// Shared types for the edge period meter.
package edge_period_meter_pkg;

   typedef enum logic [1:0] {
      PM_IDLE,
      PM_ARM,
      PM_MEASURE
   } period_meter_state_e;

endpackage

// File: rtl/edge_period_meter_if.sv
// Control and result handshake bundle between the period meter (slave) and its consumer (master).
interface edge_period_meter_if #(
   parameter int BIT_WIDTH = 8
);

   logic                 meas_en_i;
   logic                 clear_en_i;
   logic                 signal_i;
   logic [BIT_WIDTH-1:0] period_o;
   logic                 period_valid_o;
   logic                 period_ready_i;
   logic                 overflow_o;
   logic                 overrun_o;
   logic                 glitch_o;

   modport master (
      output meas_en_i, clear_en_i, signal_i, period_ready_i,
      input  period_o, period_valid_o, overflow_o, overrun_o, glitch_o
   );

   modport slave (
      input  meas_en_i, clear_en_i, signal_i, period_ready_i,
      output period_o, period_valid_o, overflow_o, overrun_o, glitch_o
   );

endinterface

// File: rtl/edge_period_meter_rise_detect.sv
// Registers a synchronised input on qualified cycles and flags its rising edge.
module edge_period_meter_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_en,
   input  logic signal,
   output logic rise
);

   logic signal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signal_q <= 1'b0;
      end else if (clk_en) begin
         signal_q <= signal;
      end
   end

   assign rise = clk_en & signal & ~signal_q;

endmodule

// File: rtl/edge_period_meter.sv
// Measures clk_en-qualified cycles between rising edges of signal_i and hands periods out over valid/ready.
// Define EDGE_PERIOD_METER_AVG_EN to report a running average instead of the raw period.
module edge_period_meter
   import edge_period_meter_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int MIN_PERIOD = 2
`ifdef EDGE_PERIOD_METER_AVG_EN
   ,parameter int AVG_SHIFT = 2
`endif
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clk_en,
   edge_period_meter_if.slave bus
);

   localparam logic [BIT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [BIT_WIDTH-1:0] MIN_P   = BIT_WIDTH'(MIN_PERIOD);

   period_meter_state_e  state;
   logic [BIT_WIDTH-1:0] count;
   logic [BIT_WIDTH-1:0] period;
   logic                 valid;
   logic                 overflow;
   logic                 overrun;
   logic                 glitch;

   logic                 rise;
   logic [BIT_WIDTH-1:0] result;
   logic [BIT_WIDTH-1:0] new_value;
   logic                 have_result;
   logic                 is_glitch;
   logic                 good;
   logic                 accept;

   edge_period_meter_rise_detect u_rise (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .signal (bus.signal_i),
      .rise   (rise)
   );

   // A rise that closes a saturated interval produces nothing; count+1 cannot wrap otherwise.
   always_comb begin
      result      = count + 1'b1;
      have_result = 1'b0;
      if (clk_en && bus.meas_en_i && (state == PM_MEASURE) && rise && (count != CNT_MAX)) begin
         have_result = 1'b1;
      end
      is_glitch = have_result && (result < MIN_P);
      good      = have_result && !is_glitch;
      accept    = good && (!valid || bus.period_ready_i);
   end

`ifdef EDGE_PERIOD_METER_AVG_EN
   logic [BIT_WIDTH-1:0] avg;
   logic [BIT_WIDTH-1:0] avg_next;
   logic                 avg_loaded;
   logic signed [BIT_WIDTH:0] diff;
   logic signed [BIT_WIDTH:0] step;
   logic signed [BIT_WIDTH:0] sum;

   always_comb begin
      diff     = $signed({1'b0, result}) - $signed({1'b0, avg});
      step     = diff >>> AVG_SHIFT;
      sum      = $signed({1'b0, avg}) + step;
      avg_next = avg_loaded ? sum[BIT_WIDTH-1:0] : result;
   end

   // The average tracks every valid period, including ones dropped for overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg        <= '0;
         avg_loaded <= 1'b0;
      end else if (bus.clear_en_i) begin
         avg_loaded <= 1'b0;
      end else if (good) begin
         avg        <= avg_next;
         avg_loaded <= 1'b1;
      end
   end

   assign new_value = avg_next;
`else
   assign new_value = result;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= PM_IDLE;
         count    <= '0;
         period   <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         overrun  <= 1'b0;
         glitch   <= 1'b0;
      end else if (bus.clear_en_i) begin
         state    <= bus.meas_en_i ? PM_ARM : PM_IDLE;
         count    <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         overrun  <= 1'b0;
         glitch   <= 1'b0;
      end else begin
         // Handshake runs every clk; only the measurement side waits for clk_en.
         if (accept) begin
            period <= new_value;
            valid  <= 1'b1;
         end else begin
            if (valid && bus.period_ready_i) valid <= 1'b0;
            if (good) overrun <= 1'b1;
         end
         if (is_glitch) glitch <= 1'b1;

         if (clk_en) begin
            if (!bus.meas_en_i) begin
               state <= PM_IDLE;
               count <= '0;
            end else begin
               case (state)
                  PM_IDLE: begin
                     state <= PM_ARM;
                     count <= '0;
                  end
                  PM_ARM: begin
                     if (rise) begin
                        state <= PM_MEASURE;
                        count <= '0;
                     end
                  end
                  PM_MEASURE: begin
                     if (rise) begin
                        count <= '0;
                     end else if (count != CNT_MAX) begin
                        count <= count + 1'b1;
                        if (count == CNT_MAX - 1'b1) overflow <= 1'b1;
                     end
                  end
                  default: state <= PM_IDLE;
               endcase
            end
         end
      end
   end

   assign bus.period_o       = period;
   assign bus.period_valid_o = valid;
   assign bus.overflow_o     = overflow;
   assign bus.overrun_o      = overrun;
   assign bus.glitch_o       = glitch;

endmodule

// File: tb/tb_edge_period_meter.sv
// Directed bench for edge_period_meter; MIN_PERIOD is raised to 3 so a period-2 input exercises the glitch path.
module tb_edge_period_meter;

   logic clk;
   logic rst_n;
   logic clk_en;
   logic half_rate;
   int   n_checks;
   int   n_fail;
   int   valid_seen;
   logic [7:0] last_period;

   edge_period_meter_if #(.BIT_WIDTH(8)) bus ();

   edge_period_meter #(
      .BIT_WIDTH  (8),
      .MIN_PERIOD (3)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock step; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (half_rate) clk_en = ~clk_en;
      if (bus.period_valid_o) begin
         valid_seen++;
         last_period = bus.period_o;
      end
   endtask

   // One square-wave period of n clocks, starting with its rising edge.
   task automatic apply_stimulus(input int n);
      bus.signal_i = 1'b1;
      repeat (n / 2) tick();
      bus.signal_i = 1'b0;
      repeat (n - n / 2) tick();
   endtask

   task automatic pulse_clear();
      bus.clear_en_i = 1'b1;
      tick();
      bus.clear_en_i = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      valid_seen = 0;
      last_period = '0;
      half_rate = 1'b0;
      clk_en = 1'b1;
      rst_n = 1'b0;
      bus.meas_en_i = 1'b0;
      bus.clear_en_i = 1'b0;
      bus.signal_i = 1'b0;
      bus.period_ready_i = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_period", 32'(bus.period_o), 0);
      check_output("reset_valid", 32'(bus.period_valid_o), 0);
      check_output("reset_overflow", 32'(bus.overflow_o), 0);
      check_output("reset_overrun", 32'(bus.overrun_o), 0);
      check_output("reset_glitch", 32'(bus.glitch_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("[TB] square wave, period 10, full rate");
      bus.meas_en_i = 1'b1;
      tick();
      apply_stimulus(10);
      valid_seen = 0;
      apply_stimulus(10);
      check_output("p10_first", 32'(last_period), 10);
      apply_stimulus(10);
      check_output("p10_valid_count", 32'(valid_seen), 2);
      check_output("p10_period", 32'(last_period), 10);

      $display("[TB] half-rate clk_en, edges 20 clocks apart");
      half_rate = 1'b1;
      pulse_clear();
      apply_stimulus(20);
      valid_seen = 0;
      apply_stimulus(20);
      apply_stimulus(20);
      check_output("half_valid_count", 32'(valid_seen), 2);
      check_output("half_period", 32'(last_period), 10);
      half_rate = 1'b0;
      clk_en = 1'b1;

      $display("[TB] overflow on a 300 cycle gap");
      pulse_clear();
      apply_stimulus(4);
      valid_seen = 0;
      repeat (300) tick();
      check_output("ovf_flag", 32'(bus.overflow_o), 1);
      check_output("ovf_no_result", 32'(valid_seen), 0);
      apply_stimulus(7);
      apply_stimulus(7);
      check_output("ovf_recover_count", 32'(valid_seen), 1);
      check_output("ovf_recover_period", 32'(last_period), 7);
      check_output("ovf_sticky", 32'(bus.overflow_o), 1);

      $display("[TB] overrun with ready held low");
      pulse_clear();
      bus.period_ready_i = 1'b0;
      apply_stimulus(12);
      apply_stimulus(12);
      apply_stimulus(9);
      apply_stimulus(5);
      check_output("ovr_period_held", 32'(bus.period_o), 12);
      check_output("ovr_valid", 32'(bus.period_valid_o), 1);
      check_output("ovr_flag", 32'(bus.overrun_o), 1);
      bus.meas_en_i = 1'b0;
      repeat (3) tick();
      check_output("idle_keeps_valid", 32'(bus.period_valid_o), 1);
      check_output("idle_keeps_period", 32'(bus.period_o), 12);
      bus.meas_en_i = 1'b1;
      bus.period_ready_i = 1'b1;
      tick();
      check_output("handshake_drop", 32'(bus.period_valid_o), 0);

      $display("[TB] glitch on period 2, boundary period 3");
      pulse_clear();
      valid_seen = 0;
      repeat (4) apply_stimulus(2);
      check_output("glitch_flag", 32'(bus.glitch_o), 1);
      check_output("glitch_no_result", 32'(valid_seen), 0);
      pulse_clear();
      check_output("glitch_cleared", 32'(bus.glitch_o), 0);
      apply_stimulus(3);
      apply_stimulus(3);
      check_output("min_period_count", 32'(valid_seen), 1);
      check_output("min_period_value", 32'(last_period), 3);
      check_output("min_period_no_glitch", 32'(bus.glitch_o), 0);

      $display("[TB] periods 16 then 32");
      pulse_clear();
      apply_stimulus(16);
      apply_stimulus(16);
      apply_stimulus(32);
      check_output("seq_first", 32'(last_period), 16);
      apply_stimulus(4);
`ifdef EDGE_PERIOD_METER_AVG_EN
      check_output("seq_second_avg", 32'(last_period), 20);
`else
      check_output("seq_second_raw", 32'(last_period), 32);
`endif

      $display("[TB] reset asserted mid-measurement");
      bus.period_ready_i = 1'b0;
      apply_stimulus(5);
      apply_stimulus(5);
      check_output("pre_reset_valid", 32'(bus.period_valid_o), 1);
      check_output("pre_reset_overrun", 32'(bus.overrun_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset_period", 32'(bus.period_o), 0);
      check_output("async_reset_valid", 32'(bus.period_valid_o), 0);
      check_output("async_reset_overrun", 32'(bus.overrun_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
